// File: rtl/i2c_slave_ctrl_if.sv
// i2c_slave_ctrl_if
// Bus-side and register-file-side signals of the I2C slave controller.
//   scl_i, sda_i         synchronised bus lines seen by the slave
//   start_det_i          START / repeated START pulse (after the following SCL fall)
//   stop_det_i           STOP pulse
//   tx_data_i            read byte from the register file
//   sda_oe_o             1 = slave pulls SDA low
//   busy_o               controller is inside a transaction
//   rx_data_o            last received write byte
//   rx_valid_o           one-cycle strobe for rx_data_o
//   rx_first_o           the strobed byte is the first after the address
//   tx_req_o             one-cycle request for the next read byte
// The slave modport is used by the controller, the master modport by whatever
// drives the bus and register file around it.
interface i2c_slave_ctrl_if;
    logic       scl_i;
    logic       sda_i;
    logic       start_det_i;
    logic       stop_det_i;
    logic [7:0] tx_data_i;
    logic       sda_oe_o;
    logic       busy_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_first_o;
    logic       tx_req_o;

    modport slave (
        input  scl_i, sda_i, start_det_i, stop_det_i, tx_data_i,
        output sda_oe_o, busy_o, rx_data_o, rx_valid_o, rx_first_o, tx_req_o
    );

    modport master (
        output scl_i, sda_i, start_det_i, stop_det_i, tx_data_i,
        input  sda_oe_o, busy_o, rx_data_o, rx_valid_o, rx_first_o, tx_req_o
    );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl
// Byte-level I2C slave: decodes the address, receives write bytes (strobing
// each one out with a first-byte flag), serves read bytes fetched from a
// register file on request, and generates ACK on SDA.
// Ports:
//   clk_i      system clock, at least 16x the SCL frequency
//   reset_n_i  asynchronous active-low reset
//   bus        i2c_slave_ctrl_if.slave (bus lines, detector pulses, byte handshakes)
module i2c_slave_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    i2c_slave_ctrl_if.slave   bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_ACK   = 3'd4;
    localparam logic [2:0] RD_DATA  = 3'd5;
    localparam logic [2:0] RD_ACK   = 3'd6;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic       byte_full;   // 8th rise seen; the byte completes at the next fall
    logic [7:0] shift;
    logic       rw;
    logic       first_byte;
    logic       scl_q;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_req;
    logic       scl_rise;
    logic       scl_fall;

    assign scl_rise = bus.scl_i & ~scl_q;
    assign scl_fall = ~bus.scl_i & scl_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            byte_full  <= 1'b0;
            shift      <= 8'h00;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            tx_req     <= 1'b0;
        end else begin
            scl_q    <= bus.scl_i;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            tx_req   <= 1'b0;
            // START wins over a coincident STOP
            if (bus.start_det_i) begin
                state     <= ADDR;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (bus.stop_det_i) begin
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                case (state)
                    ADDR, WR_DATA: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], bus.sda_i};
                            if (bit_cnt == 3'd7) byte_full <= 1'b1;
                            else                 bit_cnt   <= bit_cnt + 3'd1;
                        end else if (scl_fall && byte_full) begin
                            bit_cnt   <= 3'd0;
                            byte_full <= 1'b0;
                            if (state == ADDR) begin
                                rw <= shift[0];
                                if (shift[7:1] == DEV_ADDR) begin
                                    state  <= ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    tx_req <= shift[0];
                                end else begin
                                    state  <= IDLE;
                                end
                            end else begin
                                rx_valid   <= 1'b1;
                                rx_data    <= shift;
                                rx_first   <= first_byte;
                                first_byte <= 1'b0;
                                state      <= WR_ACK;
                                sda_oe     <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        // tx_req is high only in the first ADDR_ACK cycle of a read
                        if (tx_req) begin
                            shift <= bus.tx_data_i;
                        end else if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                state  <= RD_DATA;
                                sda_oe <= ~shift[7];
                            end else begin
                                state      <= WR_DATA;
                                sda_oe     <= 1'b0;
                                first_byte <= 1'b1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            state   <= WR_DATA;
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                        end
                    end
                    RD_DATA: begin
                        // bit7 went out on entry; each fall ends one bit
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                state   <= RD_ACK;
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                            end else begin
                                sda_oe  <= ~shift[6];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (tx_req) begin
                            shift <= bus.tx_data_i;
                        end else if (scl_rise) begin
                            if (!bus.sda_i) begin
                                tx_req <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                sda_oe <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            state   <= RD_DATA;
                            sda_oe  <= ~shift[7];
                            bit_cnt <= 3'd0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe_o   = sda_oe;
    assign bus.busy_o     = (state != IDLE);
    assign bus.rx_data_o  = rx_data;
    assign bus.rx_valid_o = rx_valid;
    assign bus.rx_first_o = rx_first;
    assign bus.tx_req_o   = tx_req;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl
// Bench acting as I2C master, start/stop detector and register file for
// i2c_slave_ctrl. Transactions are described at byte level; the expected
// ACKs, received bytes, read data and request counts follow from whether
// the address matches.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;
    localparam int         Q   = 5;       // clk cycles per quarter SCL period
    localparam logic [6:0] DEV = 7'h50;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       sda_m;                    // master's open-drain SDA drive
    logic       exp_release;              // slave must not pull SDA now
    logic [8:0] rx_q[$];                  // {first, data} expected write bytes
    logic [8:0] e;
    logic       rxv_prev;
    logic       txr_prev;
    int         txreq_seen;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] wdat [4];
    logic [7:0] rdat [4];

    i2c_slave_ctrl_if bus();

    i2c_slave_ctrl #(.DEV_ADDR(DEV)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    assign bus.sda_i = sda_m & ~bus.sda_oe_o;

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: strobes against the expected queue, SDA release.
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if (bus.rx_valid_o) begin
                chk("rx_expected", int'(rx_q.size() != 0), 1);
                if (rx_q.size() != 0) begin
                    e = rx_q.pop_front();
                    chk("rx_data", int'(bus.rx_data_o), int'(e[7:0]));
                    chk("rx_first", int'(bus.rx_first_o), int'(e[8]));
                end
                chk("rx_valid_pulse", int'(rxv_prev), 0);
            end
            if (bus.tx_req_o) begin
                txreq_seen++;
                chk("tx_req_pulse", int'(txr_prev), 0);
            end
            if (exp_release) chk("sda_released", int'(bus.sda_oe_o), 0);
        end
        rxv_prev <= bus.rx_valid_o;
        txr_prev <= bus.tx_req_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic bus_bit(input logic b, input logic rel, output logic line);
        sda_m       = b;
        exp_release = rel;
        tick(Q);
        bus.scl_i = 1'b1;
        tick(Q);
        line = bus.sda_i;
        tick(Q);
        exp_release = 1'b0;
        bus.scl_i   = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start(input logic with_stop);
        exp_release = 1'b1;
        sda_m = 1'b1;
        tick(Q);
        bus.scl_i = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        bus.scl_i = 1'b0;
        tick(1);
        bus.start_det_i = 1'b1;
        bus.stop_det_i  = with_stop;
        tick(1);
        bus.start_det_i = 1'b0;
        bus.stop_det_i  = 1'b0;
        tick(Q);
        chk("busy_after_start", int'(bus.busy_o), 1);
    endtask

    task automatic i2c_stop();
        exp_release = 1'b1;
        sda_m = 1'b0;
        tick(Q);
        bus.scl_i = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(1);
        bus.stop_det_i = 1'b1;
        tick(1);
        bus.stop_det_i = 1'b0;
        exp_release    = 1'b1;
        tick(Q);
        chk("busy_after_stop", int'(bus.busy_o), 0);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
        logic line;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], 1'b1, line);
        bus_bit(1'b1, !exp_ack, line);
        chk(name, int'(line), int'(!exp_ack));
    endtask

    task automatic read_byte(input logic master_ack, input logic rel,
                             input logic [7:0] next_tx, output logic [7:0] d);
        logic line;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, rel, line);
            d[i] = line;
        end
        bus.tx_data_i = next_tx;
        bus_bit(!master_ack, 1'b1, line);
    endtask

    // Write transaction: only a matching address is ACKed and delivers bytes.
    task automatic do_write(input logic [6:0] a7, input int n, input logic stop_after);
        logic m;
        m = (a7 == DEV);
        i2c_start(1'b0);
        write_byte({a7, 1'b0}, m, "waddr_ack");
        for (int i = 0; i < n; i++) begin
            if (m) rx_q.push_back({logic'(i == 0), wdat[i]});
            write_byte(wdat[i], m, "wdata_ack");
        end
        if (stop_after) i2c_stop();
    endtask

    // Read transaction: master ACKs all but the last byte. A matching slave
    // returns rdat[] in order and requests one byte per read byte; otherwise
    // the bus floats high and nothing is requested.
    task automatic do_read(input logic [6:0] a7, input int n);
        logic       m;
        logic [7:0] got;
        int         base;
        m    = (a7 == DEV);
        base = txreq_seen;
        bus.tx_data_i = rdat[0];
        i2c_start(1'b0);
        write_byte({a7, 1'b1}, m, "raddr_ack");
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, !m, (i + 1 < n) ? rdat[i + 1] : 8'($urandom), got);
            chk("rd_data", int'(got), m ? int'(rdat[i]) : 32'hFF);
        end
        i2c_stop();
        chk("tx_req_count", txreq_seen - base, m ? n : 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         kind;
        int         n;
        int         base;
        logic [6:0] a7;
        logic       line;

        reset_n_i       = 1'b0;
        sda_m           = 1'b1;
        exp_release     = 1'b0;
        txreq_seen      = 0;
        bus.scl_i       = 1'b1;
        bus.start_det_i = 1'b0;
        bus.stop_det_i  = 1'b0;
        bus.tx_data_i   = 8'h00;
        tick(3);
        chk("reset_sda_oe",   int'(bus.sda_oe_o),   0);
        chk("reset_busy",     int'(bus.busy_o),     0);
        chk("reset_rx_data",  int'(bus.rx_data_o),  0);
        chk("reset_rx_valid", int'(bus.rx_valid_o), 0);
        chk("reset_rx_first", int'(bus.rx_first_o), 0);
        chk("reset_tx_req",   int'(bus.tx_req_o),   0);
        reset_n_i   = 1'b1;
        exp_release = 1'b1;
        tick(5);

        // Two-byte write to 0x50: 0x12 (first) then 0x34
        wdat[0] = 8'h12;
        wdat[1] = 8'h34;
        do_write(7'h50, 2, 1'b1);
        chk("write_bytes_seen", rx_q.size(), 0);

        // Address 0xA2 is not ours: no ACK, FSM idle after the 8th bit
        base = txreq_seen;
        i2c_start(1'b0);
        write_byte(8'hA2, 1'b0, "nomatch_ack");
        chk("busy_after_nomatch", int'(bus.busy_o), 0);
        i2c_stop();
        chk("nomatch_tx_req", txreq_seen - base, 0);

        // Pointer write 0x05, repeated START, read 0x5A then 0xC3
        wdat[0] = 8'h05;
        do_write(7'h50, 1, 1'b0);
        rdat[0] = 8'h5A;
        rdat[1] = 8'hC3;
        do_read(7'h50, 2);
        chk("read_bytes_seen", rx_q.size(), 0);

        // STOP in the middle of a write byte: partial byte discarded
        i2c_start(1'b0);
        write_byte(8'hA0, 1'b1, "mid_stop_addr_ack");
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), 1'b1, line);
        i2c_stop();
        chk("mid_stop_sda_oe", int'(bus.sda_oe_o), 0);

        // START and STOP in the same cycle: START wins
        i2c_start(1'b1);
        wdat[0] = 8'h9C;
        rx_q.push_back({1'b1, 8'h9C});
        write_byte(8'hA0, 1'b1, "startstop_addr_ack");
        write_byte(8'h9C, 1'b1, "startstop_data_ack");
        i2c_stop();

        // Reset while the slave ACKs its address: SDA released with no clock edge
        i2c_start(1'b0);
        for (int i = 7; i >= 0; i--) bus_bit(logic'(((8'hA0) >> i) & 1), 1'b1, line);
        chk("ack_driven", int'(bus.sda_oe_o), 1);
        #2 reset_n_i = 1'b0;
        #1 chk("async_release", int'(bus.sda_oe_o), 0);
        chk("async_busy", int'(bus.busy_o), 0);
        tick(3);
        reset_n_i = 1'b1;
        tick(2);
        bus_bit(1'b1, 1'b1, line);
        for (int i = 0; i < 8; i++) bus_bit(1'($urandom), 1'b1, line);
        i2c_stop();
        wdat[0] = 8'($urandom);
        wdat[1] = 8'($urandom);
        do_write(7'h50, 2, 1'b1);

        // Randomised mix of writes, reads and pointer-write + read
        for (int t = 0; t < 20; t++) begin
            kind = int'($urandom_range(0, 3));
            a7   = ($urandom_range(0, 2) == 0) ? 7'($urandom) : DEV;
            n    = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) begin
                wdat[i] = 8'($urandom);
                rdat[i] = 8'($urandom);
            end
            case (kind)
                0, 1: do_write(a7, n, 1'b1);
                2:    do_read(a7, n);
                default: begin
                    do_write(DEV, 1, 1'b0);
                    do_read(a7, n);
                end
            endcase
        end

        tick(4);
        chk("all_rx_seen", rx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
